uart_puf_ctrl: RTL

Command sequencer between the `uart` byte interface and the PUF core. It parses command bytes from the UART receiver and collects challenge bytes into a challenge word. It then pulses the PUF, captures the response and streams status and response bytes back through the UART transmitter. It is the only master of the UART TX port and the PUF start line.

---
 rtl/uart_puf_pkg.sv | 31 +++
 rtl/uart_puf_ctrl_tx_seq.sv | 60 ++++++
 rtl/uart_puf_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/uart_puf_pkg.sv
// Shared constants and FSM encodings for the UART <-> PUF command sequencer.
package uart_puf_pkg;

  localparam logic [7:0] CMD_RUN   = 8'hA5;
  localparam logic [7:0] CMD_PING  = 8'h3C;

  localparam logic [7:0] ST_OK     = 8'h5A;
  localparam logic [7:0] ST_PONG   = 8'hC3;
  localparam logic [7:0] ST_BADCMD = 8'hEE;
  localparam logic [7:0] ST_RXTO   = 8'hE1;
  localparam logic [7:0] ST_FRAME  = 8'hE2;
  localparam logic [7:0] ST_PUFTO  = 8'hE3;

  typedef enum logic [2:0] {
    SIdle,
    SChal,
    SRun,
    SWait,
    SSend,
    SReply
  } main_state_e;

  typedef enum logic [2:0] {
    TIdle,
    TWaitFree,
    TPulse,
    TWaitHi,
    TWaitLo
  } tx_state_e;

endpackage

// File: rtl/uart_puf_ctrl_tx_seq.sv
// One-byte UART transmit handshake: pulse transmit, then wait for the
// transmitter's busy flag to rise and fall before reporting done.
module uart_tx_seq
  import uart_puf_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic       done,
  output logic       tx_start,
  output logic [7:0] tx_byte
);

  tx_state_e  state_q, state_d;
  logic [7:0] byte_q, byte_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= TIdle;
      byte_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    byte_d   = byte_q;
    done     = 1'b0;
    tx_start = 1'b0;
    unique case (state_q)
      TIdle: begin
        if (req) begin
          byte_d  = tx_data;
          // A transmitter still busy with someone else's byte must drain first.
          state_d = tx_busy ? TWaitFree : TPulse;
        end
      end
      TWaitFree: if (!tx_busy) state_d = TPulse;
      TPulse: begin
        tx_start = 1'b1;
        state_d  = TWaitHi;
      end
      TWaitHi: if (tx_busy) state_d = TWaitLo;
      TWaitLo: begin
        if (!tx_busy) begin
          done    = 1'b1;
          state_d = TIdle;
        end
      end
      default: state_d = TIdle;
    endcase
  end

  assign tx_byte = byte_q;

endmodule

// File: rtl/uart_puf_ctrl.sv
// Command sequencer: parses UART commands, gathers the challenge, runs the
// PUF and streams status plus response bytes back over the UART.
module uart_puf_ctrl
  import uart_puf_pkg::*;
#(
  parameter int unsigned CHAL_BYTES  = 8,
  parameter int unsigned RESP_BYTES  = 4,
  parameter int unsigned RX_TIMEOUT  = 2_000_000,
  parameter int unsigned PUF_TIMEOUT = 65535
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rx_received,
  input  logic [7:0]              rx_byte,
  input  logic                    rx_error,
  input  logic                    tx_busy,
  output logic                    tx_start,
  output logic [7:0]              tx_byte,
  output logic [8*CHAL_BYTES-1:0] puf_challenge,
  output logic                    puf_start,
  input  logic                    puf_done,
  input  logic [8*RESP_BYTES-1:0] puf_response,
  output logic                    busy
);

  localparam int unsigned RxW   = $clog2(RX_TIMEOUT + 1);
  localparam int unsigned PufW  = $clog2(PUF_TIMEOUT + 1);
  localparam int unsigned IdxW  = $clog2(CHAL_BYTES + 1);
  localparam int unsigned RIdxW = $clog2(RESP_BYTES + 1);

  localparam logic [RxW-1:0]   RxLoad  = RxW'(RX_TIMEOUT);
  localparam logic [PufW-1:0]  PufLoad = PufW'(PUF_TIMEOUT);
  localparam logic [IdxW-1:0]  LastIdx = IdxW'(CHAL_BYTES - 1);
  localparam logic [RIdxW-1:0] LastR   = RIdxW'(RESP_BYTES);

  main_state_e             state_q, state_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [8*CHAL_BYTES-1:0] chal_q, chal_d;
  logic [8*RESP_BYTES-1:0] resp_q, resp_d;
  logic [RxW-1:0]          rx_tmr_q, rx_tmr_d;
  logic [PufW-1:0]         puf_tmr_q, puf_tmr_d;
  logic [7:0]              status_q, status_d;
  logic [RIdxW-1:0]        ridx_q, ridx_d;
  logic                    issued_q, issued_d;

  logic       tx_req, tx_done;
  logic [7:0] tx_data, resp_byte;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= SIdle;
      idx_q     <= '0;
      chal_q    <= '0;
      resp_q    <= '0;
      rx_tmr_q  <= '0;
      puf_tmr_q <= '0;
      status_q  <= 8'h00;
      ridx_q    <= '0;
      issued_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      chal_q    <= chal_d;
      resp_q    <= resp_d;
      rx_tmr_q  <= rx_tmr_d;
      puf_tmr_q <= puf_tmr_d;
      status_q  <= status_d;
      ridx_q    <= ridx_d;
      issued_q  <= issued_d;
    end
  end

  // ridx 0 is the OK header; ridx k selects response byte k-1.
  always_comb begin
    resp_byte = 8'h00;
    for (int i = 0; i < int'(RESP_BYTES); i++) begin
      if (ridx_q == RIdxW'(i + 1)) resp_byte = resp_q[8*i +: 8];
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    chal_d    = chal_q;
    resp_d    = resp_q;
    rx_tmr_d  = rx_tmr_q;
    puf_tmr_d = puf_tmr_q;
    status_d  = status_q;
    ridx_d    = ridx_q;
    issued_d  = issued_q;
    puf_start = 1'b0;
    tx_req    = 1'b0;
    tx_data   = status_q;

    unique case (state_q)
      SIdle: begin
        if (rx_received) begin
          if (rx_byte == CMD_RUN) begin
            state_d  = SChal;
            idx_d    = '0;
            rx_tmr_d = RxLoad;
          end else begin
            state_d  = SReply;
            status_d = (rx_byte == CMD_PING) ? ST_PONG : ST_BADCMD;
          end
        end
      end
      SChal: begin
        // Error beats a simultaneous byte; a byte beats a simultaneous expiry.
        if (rx_error) begin
          state_d  = SReply;
          status_d = ST_FRAME;
        end else if (rx_received) begin
          for (int i = 0; i < int'(CHAL_BYTES); i++) begin
            if (idx_q == IdxW'(i)) chal_d[8*i +: 8] = rx_byte;
          end
          rx_tmr_d = RxLoad;
          if (idx_q == LastIdx) begin
            idx_d   = '0;
            state_d = SRun;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else if (rx_tmr_q == '0) begin
          state_d  = SReply;
          status_d = ST_RXTO;
        end else begin
          rx_tmr_d = rx_tmr_q - 1'b1;
        end
      end
      SRun: begin
        puf_start = 1'b1;
        puf_tmr_d = PufLoad;
        state_d   = SWait;
      end
      SWait: begin
        if (puf_done) begin
          resp_d  = puf_response;
          ridx_d  = '0;
          state_d = SSend;
        end else if (puf_tmr_q == '0) begin
          state_d  = SReply;
          status_d = ST_PUFTO;
        end else begin
          puf_tmr_d = puf_tmr_q - 1'b1;
        end
      end
      SSend: begin
        tx_data  = (ridx_q == '0) ? ST_OK : resp_byte;
        tx_req   = !issued_q;
        issued_d = 1'b1;
        if (tx_done) begin
          issued_d = 1'b0;
          if (ridx_q == LastR) state_d = SIdle;
          else                 ridx_d  = ridx_q + 1'b1;
        end
      end
      SReply: begin
        tx_req   = !issued_q;
        issued_d = 1'b1;
        if (tx_done) begin
          issued_d = 1'b0;
          state_d  = SIdle;
        end
      end
      default: state_d = SIdle;
    endcase
  end

  uart_tx_seq u_tx_seq (
    .clk      (clk),
    .rst      (rst),
    .req      (tx_req),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .done     (tx_done),
    .tx_start (tx_start),
    .tx_byte  (tx_byte)
  );

  assign puf_challenge = chal_q;
  assign busy          = (state_q != SIdle);

endmodule
